// File: rtl/reg_scoreboard_pkg.sv
// Shared register-scoreboard parameters, stall-cause encodings and helpers.
// Imported by the scoreboard, its hazard checker and its interface.
package reg_scoreboard_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS);

    localparam logic [1:0] STALL_RAW = 2'b01;
    localparam logic [1:0] STALL_WAW = 2'b10;

    typedef logic [NUM_REGS-1:0] reg_vec_t;
    typedef logic [ADDR_W-1:0]   reg_addr_t;
    typedef logic [ADDR_W:0]     reg_cnt_t;

    function automatic reg_cnt_t popcount(input reg_vec_t v);
        reg_cnt_t cnt;
        cnt = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            cnt = cnt + reg_cnt_t'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue / writeback / status bundle between decode, writeback and the scoreboard.
// master = pipeline side, slave = scoreboard side.
interface reg_scoreboard_if;
    import reg_scoreboard_pkg::*;

    logic       issue_valid_i;
    reg_addr_t  issue_rs1_addr_i;
    reg_addr_t  issue_rs2_addr_i;
    logic       issue_rs1_used_i;
    logic       issue_rs2_used_i;
    reg_addr_t  issue_rd_addr_i;
    logic       issue_rd_wen_i;
    logic       issue_ready_o;
    logic [1:0] stall_cause_o;
    logic       wb_valid_i;
    reg_addr_t  wb_rd_addr_i;
    logic       flush_i;
    reg_cnt_t   outstanding_o;
    logic       err_o;

    modport master (
        output issue_valid_i, issue_rs1_addr_i, issue_rs2_addr_i,
               issue_rs1_used_i, issue_rs2_used_i, issue_rd_addr_i,
               issue_rd_wen_i, wb_valid_i, wb_rd_addr_i, flush_i,
        input  issue_ready_o, stall_cause_o, outstanding_o, err_o
    );

    modport slave (
        input  issue_valid_i, issue_rs1_addr_i, issue_rs2_addr_i,
               issue_rs1_used_i, issue_rs2_used_i, issue_rd_addr_i,
               issue_rd_wen_i, wb_valid_i, wb_rd_addr_i, flush_i,
        output issue_ready_o, stall_cause_o, outstanding_o, err_o
    );

endinterface

// File: rtl/sb_hazard_check.sv
// Combinational RAW/WAW detection of one issuing instruction against the
// effective busy vector. x0 is never a hazard.
module sb_hazard_check
    import reg_scoreboard_pkg::*;
(
    input  reg_vec_t  eff_busy,
    input  reg_addr_t rs1_addr,
    input  logic      rs1_used,
    input  reg_addr_t rs2_addr,
    input  logic      rs2_used,
    input  reg_addr_t rd_addr,
    input  logic      rd_wen,
    output logic      raw,
    output logic      waw
);

    always_comb begin
        raw = (rs1_used && (rs1_addr != '0) && eff_busy[rs1_addr]) ||
              (rs2_used && (rs2_addr != '0) && eff_busy[rs2_addr]);
        waw = rd_wen && (rd_addr != '0) && eff_busy[rd_addr];
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-file scoreboard: tracks in-flight writes and stalls issue on RAW/WAW.
// Optional macro SB_WB_BYPASS_EN lets a same-cycle writeback hide the busy bit.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    reg_scoreboard_if.slave sb
);

    logic [NUM_REGS-1:1] busy_q;
    reg_vec_t            busy;
    reg_vec_t            eff_busy;
    reg_vec_t            wb_mask;
    reg_vec_t            busy_nxt;
    reg_cnt_t            outstanding_q;
    logic                err_q;
    logic                err_set;
    logic                raw;
    logic                waw;
    logic                ready;
    logic                fire;

    assign busy = {busy_q, 1'b0};

    // One-hot of the register being retired; x0 writebacks never appear here.
    always_comb begin
        wb_mask = '0;
        wb_mask[sb.wb_rd_addr_i] = sb.wb_valid_i && (sb.wb_rd_addr_i != '0);
    end

`ifdef SB_WB_BYPASS_EN
    assign eff_busy = busy & ~wb_mask;
`else
    assign eff_busy = busy;
`endif

    sb_hazard_check u_hazard (
        .eff_busy (eff_busy),
        .rs1_addr (sb.issue_rs1_addr_i),
        .rs1_used (sb.issue_rs1_used_i),
        .rs2_addr (sb.issue_rs2_addr_i),
        .rs2_used (sb.issue_rs2_used_i),
        .rd_addr  (sb.issue_rd_addr_i),
        .rd_wen   (sb.issue_rd_wen_i),
        .raw      (raw),
        .waw      (waw)
    );

    assign ready = ~sb.flush_i & ~raw & ~waw;
    assign fire  = sb.issue_valid_i & ready;

    // Clear first so a same-register set in this cycle wins; flush overrides all.
    always_comb begin
        busy_nxt = busy & ~wb_mask;
        err_set  = ~sb.flush_i & (|(wb_mask & ~busy));
        if (fire && sb.issue_rd_wen_i && (sb.issue_rd_addr_i != '0)) begin
            busy_nxt[sb.issue_rd_addr_i] = 1'b1;
        end
        if (sb.flush_i) begin
            busy_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q        <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            busy_q        <= busy_nxt[NUM_REGS-1:1];
            outstanding_q <= popcount(busy_nxt);
            err_q         <= err_q | err_set;
        end
    end

    assign sb.issue_ready_o = ready;
    assign sb.stall_cause_o = sb.flush_i ? 2'b00
                            : ((waw ? STALL_WAW : 2'b00) | (raw ? STALL_RAW : 2'b00));
    assign sb.outstanding_o = outstanding_q;
    assign sb.err_o         = err_q;

endmodule
